// File: rtl/mem_dp_if.sv
// Purpose: port bundle for the dual-port memory mem_dp.
//   Port A: read/write with byte enables (iw_a_*), read return or_a_rdata/or_a_rvalid.
//   Port B: read-only (iw_b_*), read return or_b_rdata/or_b_rvalid.
//   or_busy: high while the post-reset clear sweep runs.
// The requester uses the master modport; the memory uses the slave modport.
interface mem_dp_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 12
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              iw_a_req;
  logic              iw_a_we;
  logic [ADDR_W-1:0] iw_a_addr;
  logic [BE_W-1:0]   iw_a_be;
  logic [DATA_W-1:0] iw_a_wdata;
  logic [DATA_W-1:0] or_a_rdata;
  logic              or_a_rvalid;
  logic              iw_b_req;
  logic [ADDR_W-1:0] iw_b_addr;
  logic [DATA_W-1:0] or_b_rdata;
  logic              or_b_rvalid;
  logic              or_busy;

  modport master (
    output iw_a_req, iw_a_we, iw_a_addr, iw_a_be, iw_a_wdata,
    output iw_b_req, iw_b_addr,
    input  or_a_rdata, or_a_rvalid, or_b_rdata, or_b_rvalid, or_busy
  );

  modport slave (
    input  iw_a_req, iw_a_we, iw_a_addr, iw_a_be, iw_a_wdata,
    input  iw_b_req, iw_b_addr,
    output or_a_rdata, or_a_rvalid, or_b_rdata, or_b_rvalid, or_busy
  );
endinterface

// File: rtl/mem_dp.sv
// Purpose: dual-port word memory, port A read/write with byte enables, port B
// read-only, read-first on same-address collisions, 1- or 2-cycle read latency,
// optional zero-fill sweep after reset (requests dropped while or_busy=1).
// Ports:
//   iw_clk   - sole clock, rising edge
//   iw_rst_n - asynchronous active-low reset
//   bus      - mem_dp_if slave modport (port A, port B, or_busy)
module mem_dp #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned CLEAR_EN = 1
) (
  input  logic     iw_clk,
  input  logic     iw_rst_n,
  mem_dp_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BYTES = DATA_W / 8;

  // Elaboration-time parameter legality
  generate
    if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
      $error("mem_dp: DATA_W must be a non-zero multiple of 8");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
      $error("mem_dp: READ_LAT must be 1 or 2");
    end
  endgenerate

  // READY encodes as 0 so the reset value of the state register is zero
  typedef enum logic {
    S_READY = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_boot;
  logic              r_busy;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_clr_we;
  logic              w_ready;
  logic              w_a_rd;
  logic              w_a_wr;
  logic              w_b_rd;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_a_v1;
  logic              r_b_v1;
  logic [DATA_W-1:0] r_a_d1;
  logic [DATA_W-1:0] r_b_d1;

  // State register; r_boot marks the first edge after reset release
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_state   <= S_READY;
      r_boot    <= 1'b0;
      r_busy    <= 1'b0;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_boot    <= 1'b1;
      r_busy    <= (w_next_state == S_CLEAR);
      r_clr_cnt <= w_clr_we ? (r_clr_cnt + ADDR_W'(1)) : '0;
    end
  end

  // Next-state: sweep starts on the first edge after release, ends after DEPTH-1
  always_comb begin
    w_next_state = r_state;
    w_clr_we     = 1'b0;
    case (r_state)
      S_READY: begin
        if (!r_boot && (CLEAR_EN != 0)) begin
          w_next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_clr_we = 1'b1;
        if (&r_clr_cnt) begin
          w_next_state = S_READY;
        end
      end
      default: w_next_state = S_READY;
    endcase
  end

  // Requests are accepted only once the controller has settled in READY
  assign w_ready = (r_state == S_READY) && (r_boot || (CLEAR_EN == 0));
  assign w_a_rd  = w_ready && bus.iw_a_req && !bus.iw_a_we;
  assign w_a_wr  = w_ready && bus.iw_a_req &&  bus.iw_a_we;
  assign w_b_rd  = w_ready && bus.iw_b_req;

  // Array write port: clear sweep or byte-masked port A write; never reset
  always_ff @(posedge iw_clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_a_wr) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (bus.iw_a_be[i]) begin
          r_mem[bus.iw_a_addr][8*i +: 8] <= bus.iw_a_wdata[8*i +: 8];
        end
      end
    end
  end

  // First read stage; non-blocking read of r_mem gives read-first collisions
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_a_v1 <= 1'b0;
      r_b_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_d1 <= '0;
    end else begin
      r_a_v1 <= w_a_rd;
      r_b_v1 <= w_b_rd;
      if (w_a_rd) begin
        r_a_d1 <= r_mem[bus.iw_a_addr];
      end
      if (w_b_rd) begin
        r_b_d1 <= r_mem[bus.iw_b_addr];
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_a_v2;
      logic              r_b_v2;
      logic [DATA_W-1:0] r_a_d2;
      logic [DATA_W-1:0] r_b_d2;

      // Plain pipeline stage; data only moves with its valid so rdata holds
      always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
          r_a_v2 <= 1'b0;
          r_b_v2 <= 1'b0;
          r_a_d2 <= '0;
          r_b_d2 <= '0;
        end else begin
          r_a_v2 <= r_a_v1;
          r_b_v2 <= r_b_v1;
          if (r_a_v1) begin
            r_a_d2 <= r_a_d1;
          end
          if (r_b_v1) begin
            r_b_d2 <= r_b_d1;
          end
        end
      end

      assign bus.or_a_rvalid = r_a_v2;
      assign bus.or_a_rdata  = r_a_d2;
      assign bus.or_b_rvalid = r_b_v2;
      assign bus.or_b_rdata  = r_b_d2;
    end else begin : g_lat1
      assign bus.or_a_rvalid = r_a_v1;
      assign bus.or_a_rdata  = r_a_d1;
      assign bus.or_b_rvalid = r_b_v1;
      assign bus.or_b_rdata  = r_b_d1;
    end
  endgenerate

  assign bus.or_busy = r_busy;

endmodule

// File: tb/tb_mem_dp.sv
// Bench for mem_dp: one READ_LAT=1 and one READ_LAT=2 instance driven with the
// same stimulus, compared each cycle against a behavioural model.
module tb_mem_dp;

  localparam int unsigned DW    = 24;
  localparam int unsigned AW    = 12;
  localparam int unsigned NB    = DW / 8;
  localparam int          DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [NB-1:0] a_be;
  logic [DW-1:0] a_wdata;
  logic          b_req;
  logic [AW-1:0] b_addr;

  mem_dp_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  mem_dp_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

  assign if1.iw_a_req   = a_req;
  assign if1.iw_a_we    = a_we;
  assign if1.iw_a_addr  = a_addr;
  assign if1.iw_a_be    = a_be;
  assign if1.iw_a_wdata = a_wdata;
  assign if1.iw_b_req   = b_req;
  assign if1.iw_b_addr  = b_addr;
  assign if2.iw_a_req   = a_req;
  assign if2.iw_a_we    = a_we;
  assign if2.iw_a_addr  = a_addr;
  assign if2.iw_a_be    = a_be;
  assign if2.iw_a_wdata = a_wdata;
  assign if2.iw_b_req   = b_req;
  assign if2.iw_b_addr  = b_addr;

  mem_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .CLEAR_EN(1)) u_dut1 (
    .iw_clk(clk), .iw_rst_n(rst_n), .bus(if1)
  );
  mem_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2), .CLEAR_EN(1)) u_dut2 (
    .iw_clk(clk), .iw_rst_n(rst_n), .bus(if2)
  );

  logic [DW-1:0] o_ard [2];
  logic [DW-1:0] o_brd [2];
  logic          o_av  [2];
  logic          o_bv  [2];
  logic          o_busy[2];
  assign o_ard[0]  = if1.or_a_rdata;
  assign o_ard[1]  = if2.or_a_rdata;
  assign o_brd[0]  = if1.or_b_rdata;
  assign o_brd[1]  = if2.or_b_rdata;
  assign o_av[0]   = if1.or_a_rvalid;
  assign o_av[1]   = if2.or_a_rvalid;
  assign o_bv[0]   = if1.or_b_rvalid;
  assign o_bv[1]   = if2.or_b_rvalid;
  assign o_busy[0] = if1.or_busy;
  assign o_busy[1] = if2.or_busy;

  int checks   = 0;
  int failures = 0;

  // ---- behavioural model ----
  typedef struct {
    logic          av;
    logic [DW-1:0] ad;
    logic          bv;
    logic [DW-1:0] bd;
  } rd_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rd_t           ring    [4];
  int            e;
  bit            started;
  bit            m_busy;
  int            clr_left;
  logic [DW-1:0] hold_a [2];
  logic [DW-1:0] hold_b [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_req = 1'b0; b_addr = '0;
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      rd_t s;
      s = ring[(e - d) % 4];
      if (s.av) hold_a[d] = s.ad;
      if (s.bv) hold_b[d] = s.bd;
      chk($sformatf("d%0d_busy", d + 1), 32'(o_busy[d]), 32'(m_busy));
      chk($sformatf("d%0d_a_rvalid", d + 1), 32'(o_av[d]), 32'(s.av));
      chk($sformatf("d%0d_a_rdata", d + 1), 32'(o_ard[d]), 32'(hold_a[d]));
      chk($sformatf("d%0d_b_rvalid", d + 1), 32'(o_bv[d]), 32'(s.bv));
      chk($sformatf("d%0d_b_rdata", d + 1), 32'(o_brd[d]), 32'(hold_b[d]));
    end
  endtask

  // One clock edge: update the model from the sampled inputs, then check both DUTs
  task automatic step();
    bit            ok;
    rd_t           r;
    @(posedge clk);
    ok   = started && !m_busy;
    r.av = ok && a_req && !a_we;
    r.bv = ok && b_req;
    r.ad = ref_mem[a_addr];
    r.bd = ref_mem[b_addr];
    if (ok && a_req && a_we) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (a_be[i]) ref_mem[a_addr][8*i +: 8] = a_wdata[8*i +: 8];
      end
    end
    if (!started) begin
      started  = 1'b1;
      clr_left = DEPTH;
      m_busy   = 1'b1;
    end else if (clr_left > 0) begin
      clr_left--;
      m_busy = (clr_left > 0);
    end
    e++;
    ring[e % 4] = r;
    #1;
    check_outputs();
  endtask

  // Assert reset now, hold for n edges, release a little after an edge
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    started = 1'b0; m_busy = 1'b0; clr_left = 0;
    for (int k = 0; k < 4; k++) ring[k] = '{1'b0, '0, 1'b0, '0};
    for (int d = 0; d < 2; d++) begin hold_a[d] = '0; hold_b[d] = '0; end
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_d%0d_busy", d + 1), 32'(o_busy[d]), 32'd0);
      chk($sformatf("rst_d%0d_a_rvalid", d + 1), 32'(o_av[d]), 32'd0);
      chk($sformatf("rst_d%0d_b_rvalid", d + 1), 32'(o_bv[d]), 32'd0);
      chk($sformatf("rst_d%0d_a_rdata", d + 1), 32'(o_ard[d]), 32'd0);
      chk($sformatf("rst_d%0d_b_rdata", d + 1), 32'(o_brd[d]), 32'd0);
    end
    repeat (n) @(posedge clk);
    #1;
    chk("rst_hold_d2_a_rvalid", 32'(o_av[1]), 32'd0);
    chk("rst_hold_d2_b_rvalid", 32'(o_bv[1]), 32'd0);
    chk("rst_hold_busy", 32'(o_busy[0]), 32'd0);
    rst_n = 1'b1;
  endtask

  // Step until the sweep finishes (bounded); n = cycles seen with busy high
  task automatic wait_ready(output int n);
    int k;
    k = 0;
    n = 0;
    do begin
      step();
      k++;
      if (o_busy[0] === 1'b1) n++;
    end while ((k < 2 || o_busy[0] === 1'b1) && k < DEPTH + 64);
  endtask

  // ---- directed vectors ----
  typedef struct {
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [NB-1:0] a_be;
    logic [DW-1:0] a_wdata;
    logic          b_req;
    logic [AW-1:0] b_addr;
    logic          chk_a;
    logic [DW-1:0] exp_a;
    logic          chk_b;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t vt [13];

  initial begin
    int n0;
    int n1;
    int cnt;
    int first;
    int last;

    vt[0]  = '{1'b0, 1'b0, 12'h000, 3'b000, 24'h000000, 1'b1, 12'h000, 1'b0, 24'h0,      1'b1, 24'h000000};
    vt[1]  = '{1'b0, 1'b0, 12'h000, 3'b000, 24'h000000, 1'b1, 12'h7FF, 1'b0, 24'h0,      1'b1, 24'h000000};
    vt[2]  = '{1'b0, 1'b0, 12'h000, 3'b000, 24'h000000, 1'b1, 12'hFFF, 1'b0, 24'h0,      1'b1, 24'h000000};
    vt[3]  = '{1'b1, 1'b1, 12'h010, 3'b111, 24'hAABBCC, 1'b0, 12'h000, 1'b0, 24'h0,      1'b0, 24'h000000};
    vt[4]  = '{1'b1, 1'b1, 12'h010, 3'b010, 24'h112233, 1'b0, 12'h000, 1'b0, 24'h0,      1'b0, 24'h000000};
    vt[5]  = '{1'b1, 1'b0, 12'h010, 3'b000, 24'h000000, 1'b1, 12'h010, 1'b1, 24'hAA22CC, 1'b1, 24'hAA22CC};
    vt[6]  = '{1'b1, 1'b1, 12'h020, 3'b111, 24'h000005, 1'b0, 12'h000, 1'b0, 24'h0,      1'b0, 24'h000000};
    vt[7]  = '{1'b1, 1'b1, 12'h020, 3'b111, 24'h00000F, 1'b1, 12'h020, 1'b0, 24'h0,      1'b1, 24'h000005};
    vt[8]  = '{1'b0, 1'b0, 12'h000, 3'b000, 24'h000000, 1'b1, 12'h020, 1'b0, 24'h0,      1'b1, 24'h00000F};
    vt[9]  = '{1'b1, 1'b1, 12'h010, 3'b000, 24'hFFFFFF, 1'b0, 12'h000, 1'b0, 24'h0,      1'b0, 24'h000000};
    vt[10] = '{1'b1, 1'b0, 12'h010, 3'b000, 24'h000000, 1'b1, 12'hFFF, 1'b1, 24'hAA22CC, 1'b1, 24'h000000};
    vt[11] = '{1'b1, 1'b1, 12'hFFF, 3'b101, 24'hDEADBE, 1'b0, 12'h000, 1'b0, 24'h0,      1'b0, 24'h000000};
    vt[12] = '{1'b1, 1'b0, 12'h000, 3'b000, 24'h000000, 1'b1, 12'hFFF, 1'b1, 24'h000000, 1'b1, 24'hDE00BE};

    e = 8;
    idle();
    rst_n = 1'b0;
    #12;
    do_reset(3);
    wait_ready(n0);
    chk("clear_len", 32'(n0), 32'(DEPTH));

    // Directed table: each op followed by an idle cycle so both latencies drain
    for (int i = 0; i < 13; i++) begin
      a_req = vt[i].a_req; a_we = vt[i].a_we; a_addr = vt[i].a_addr;
      a_be = vt[i].a_be; a_wdata = vt[i].a_wdata;
      b_req = vt[i].b_req; b_addr = vt[i].b_addr;
      step();
      idle();
      if (vt[i].chk_a) chk($sformatf("vec%0d_d1_a", i), 32'(o_ard[0]), 32'(vt[i].exp_a));
      if (vt[i].chk_b) chk($sformatf("vec%0d_d1_b", i), 32'(o_brd[0]), 32'(vt[i].exp_b));
      step();
      if (vt[i].chk_a) chk($sformatf("vec%0d_d2_a", i), 32'(o_ard[1]), 32'(vt[i].exp_a));
      if (vt[i].chk_b) chk($sformatf("vec%0d_d2_b", i), 32'(o_brd[1]), 32'(vt[i].exp_b));
    end

    // Throughput: fill 0x000..0x00F, then 16 back-to-back B reads
    for (int i = 0; i < 16; i++) begin
      a_req = 1'b1; a_we = 1'b1; a_addr = AW'(i); a_be = '1; a_wdata = DW'($urandom);
      step();
    end
    idle();
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin b_req = 1'b1; b_addr = AW'(i); end
      else idle();
      step();
      if (o_bv[1] === 1'b1) begin
        chk($sformatf("thru_data%0d", cnt), 32'(o_brd[1]), 32'(ref_mem[cnt]));
        if (first < 0) first = e;
        last = e;
        cnt++;
      end
    end
    chk("thru_count", 32'(cnt), 32'd16);
    chk("thru_span", 32'(last - first + 1), 32'd16);

    // Randomized traffic, narrow address range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      a_req   = 1'($urandom);
      a_we    = 1'($urandom);
      a_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      a_be    = NB'($urandom);
      a_wdata = DW'($urandom);
      b_req   = 1'($urandom);
      b_addr  = ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, 15));
      step();
    end
    idle();
    step();
    step();

    // Reset with reads in flight: the latency-2 pulses must not appear
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010;
    b_req = 1'b1; b_addr = 12'h020;
    step();
    idle();
    #2;
    do_reset(2);

    // Requests issued during the sweep are dropped
    n0 = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (o_busy[0] === 1'b1) n0++;
    end
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h005; a_be = '1; a_wdata = 24'h123456;
    step();
    if (o_busy[0] === 1'b1) n0++;
    a_we = 1'b0; b_req = 1'b1; b_addr = 12'h005;
    step();
    if (o_busy[0] === 1'b1) n0++;
    idle();
    wait_ready(n1);
    chk("drop_clear_len", 32'(n0 + n1), 32'(DEPTH));
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h005;
    step();
    idle();
    chk("drop_d1_valid", 32'(o_av[0]), 32'd1);
    chk("drop_d1_data", 32'(o_ard[0]), 32'h000000);
    step();
    chk("drop_d2_data", 32'(o_ard[1]), 32'h000000);

    // Mid-sweep reset at clear count 100, then a full sweep again
    do_reset(2);
    for (int i = 0; i < 200 && !(started && clr_left == DEPTH - 100); i++) step();
    chk("mid_busy_before", 32'(o_busy[0]), 32'd1);
    #2;
    do_reset(3);
    wait_ready(n1);
    chk("mid_clear_len", 32'(n1), 32'(DEPTH));
    b_req = 1'b1; b_addr = 12'h7FF;
    step();
    idle();
    step();
    chk("mid_d2_b_data", 32'(o_brd[1]), 32'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dp.md
MEM_DP -- requirements
Module: mem_dp

Interface
REQ-001 Parameter DATA_W, default 24, sets the data word width in bits; it SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 12, sets the address width; DEPTH SHALL be 2**ADDR_W words.
REQ-003 Parameter READ_LAT, default 1, sets the read latency in cycles; legal values are 1 and 2.
REQ-004 Parameter CLEAR_EN, default 1; when 1, the array SHALL be zero-filled after reset.
REQ-005 iw_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 iw_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 iw_a_req  input  1  port A access request.
REQ-008 iw_a_we  input  1  port A write when high, read when low.
REQ-009 iw_a_addr  input  ADDR_W  port A word address.
REQ-010 iw_a_be  input  DATA_W/8  port A byte enables; bit i qualifies wdata[8i+7:8i].
REQ-011 iw_a_wdata  input  DATA_W  port A write data.
REQ-012 or_a_rdata  output  DATA_W  port A read data.
REQ-013 or_a_rvalid  output  1  port A read data valid, one-cycle pulse per accepted read.
REQ-014 iw_b_req  input  1  port B read request (port B is read-only).
REQ-015 iw_b_addr  input  ADDR_W  port B word address.
REQ-016 or_b_rdata  output  DATA_W  port B read data.
REQ-017 or_b_rvalid  output  1  port B read data valid pulse.
REQ-018 or_busy  output  1  high while the clear sweep runs; all requests are ignored while high.

Function
REQ-019 The controller SHALL have two states: CLEAR and READY.
REQ-020 After reset release, the controller SHALL enter CLEAR if CLEAR_EN=1, else READY.
REQ-021 In CLEAR, an ADDR_W-bit counter SHALL start at 0 and write all-zero to one address per cycle.
REQ-022 CLEAR SHALL go to READY in the cycle after address DEPTH-1 is written; CLEAR lasts exactly DEPTH cycles.
REQ-023 or_busy SHALL equal 1 exactly while the controller is in CLEAR.
REQ-024 While or_busy=1, requests on both ports SHALL be dropped: no write occurs and no rvalid is issued.
REQ-025 In READY, a request with iw_a_req=1 and iw_a_we=1 SHALL write only the enabled bytes; disabled bytes keep their prior value.
REQ-026 A port A write SHALL NOT produce or_a_rvalid.
REQ-027 A write with iw_a_be all zero SHALL leave the array unchanged.
REQ-028 A read accepted at edge N SHALL present data with rvalid=1 after edge N+READ_LAT, for exactly one cycle per request.
REQ-029 Back-to-back reads SHALL be accepted every cycle with full throughput and no bubbles.
REQ-030 rdata SHALL hold its last value while rvalid=0.
REQ-031 A port A write and a port B read to the same address in the same cycle SHALL return the old data on B (read-first).
REQ-032 With READ_LAT=2, the second stage SHALL be a plain pipeline register; the same collision behaviour (REQ-031) SHALL hold.
REQ-033 Both ports SHALL read the same address in the same cycle independently, with identical data.
REQ-034 Addresses SHALL be used unmodified; there is no wrap or bounds logic beyond the ADDR_W width.

Reset
REQ-035 On iw_rst_n=0: controller state, clear counter, rvalid pipeline bits and rdata registers SHALL clear to 0 asynchronously; or_busy SHALL go to 0.
REQ-036 Array contents SHALL NOT be reset directly; they change only through the clear sweep.
REQ-037 A reset asserted during CLEAR SHALL abort the sweep; after release the sweep SHALL restart at address 0.
REQ-038 A reset asserted during a read in flight SHALL suppress the pending rvalid.

Verification
REQ-039 Clear: release reset with CLEAR_EN=1 -> or_busy=1 for 4096 cycles; then B reads of 0x000, 0x7FF and 0xFFF each return 0x000000.
REQ-040 Byte enable: A writes 0xAABBCC to 0x010, then writes 0x112233 with be=3'b010 -> A read of 0x010 returns 0xAA22CC with rvalid after READ_LAT cycles.
REQ-041 Collision: 0x020 holds 0x000005; A writes 0x00000F to 0x020 while B reads 0x020 -> B gets 0x000005; B's next read gets 0x00000F.
REQ-042 Throughput: B reads 0x000..0x00F on consecutive cycles with READ_LAT=2 -> 16 consecutive rvalid pulses with data in address order.
REQ-043 Busy drop: A write of 0x123456 to 0x005 issued during CLEAR -> no rvalid; 0x005 reads 0x000000 after READY.
REQ-044 Mid-clear reset: assert reset at clear count 100 -> or_busy=0 immediately; after release, the sweep runs a full 4096 cycles again.
